// File: rtl/pipe_sample_reader.sv
// pipe_sample_reader: on an accepted L1A, copies NSAMP consecutive pipeline
// words into a 32-entry circular sample buffer. Each entry is tagged with the
// event number and first/last/error flags. The buffer drains through a
// registered first-word-fall-through valid/ready output stage. Refused
// triggers are counted (saturating) rather than queued.
module pipe_sample_reader #(
   parameter int DW     = 192,
   parameter int ADDR_W = 5
) (
   input  logic              RDCLK,
   input  logic              RST,
   input  logic              PIP_VALID,
   input  logic              L1A,
   input  logic [4:0]        NSAMP,
   input  logic [DW-1:0]     PIPOUT,
   output logic [DW-1:0]     DOUT,
   output logic [11:0]       DOUT_EVT,
   output logic              DOUT_FIRST,
   output logic              DOUT_LAST,
   output logic              DOUT_ERR,
   output logic              DOUT_VALID,
   input  logic              DOUT_READY,
   output logic              BUSY,
   output logic [11:0]       L1A_CNT,
   output logic [7:0]        MISS_CNT,
   output logic [ADDR_W:0]   BUF_CNT
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int EW    = DW + 15;   // {ERR, LAST, FIRST, EVT[11:0], DATA}

   typedef enum logic {S_IDLE, S_CAPTURE} state_t;

   state_t              state_q, state_d;
   logic [4:0]          nsamp_q, nsamp_d;
   logic [4:0]          idx_q, idx_d;
   logic [11:0]         evt_q, evt_d;
   logic [11:0]         l1a_cnt_q;
   logic [7:0]          miss_cnt_q;
   logic [ADDR_W:0]     cnt_q;

   // Pointers carry one extra wrap bit so a full buffer differs from an empty one.
   logic [ADDR_W:0]     wr_ptr_q;
   logic [ADDR_W:0]     wr_ptr_dly_q;
   logic [ADDR_W:0]     rd_ptr_q;

   logic [EW-1:0]       mem [DEPTH];

   logic [DW-1:0]       dout_data_q;
   logic [11:0]         dout_evt_q;
   logic                dout_first_q, dout_last_q, dout_err_q, dout_vld_q;

   logic [4:0]          eff_nsamp;
   logic                space_ok;
   logic                wr_en;
   logic [EW-1:0]       wr_word;
   logic                miss_inc;
   logic                pop;
   logic                load;
   logic                avail;
   logic [ADDR_W:0]     head_nxt;
   logic [EW-1:0]       mem_rd;

   // Out-of-range sample counts fall back to the 16-sample maximum.
   assign eff_nsamp = (NSAMP == 5'd0 || NSAMP > 5'd16) ? 5'd16 : NSAMP;
   // Space check uses the registered occupancy only; a same-cycle pop gives no credit.
   assign space_ok  = (32'(DEPTH) - 32'(cnt_q)) >= 32'(eff_nsamp);

   // Capture FSM: accepts triggers in IDLE, streams the remaining samples in CAPTURE.
   always_comb begin
      state_d  = state_q;
      nsamp_d  = nsamp_q;
      idx_d    = idx_q;
      evt_d    = evt_q;
      wr_en    = 1'b0;
      wr_word  = '0;
      miss_inc = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (L1A) begin
               if (PIP_VALID && space_ok) begin
                  wr_en   = 1'b1;
                  wr_word = {1'b0, (eff_nsamp == 5'd1), 1'b1, l1a_cnt_q, PIPOUT};
                  nsamp_d = eff_nsamp;
                  evt_d   = l1a_cnt_q;
                  idx_d   = 5'd1;
                  if (eff_nsamp != 5'd1) state_d = S_CAPTURE;
               end else begin
                  miss_inc = 1'b1;
               end
            end
         end
         S_CAPTURE: begin
            wr_en   = 1'b1;
            wr_word = {~PIP_VALID, (idx_q == nsamp_q - 5'd1), 1'b0, evt_q, PIPOUT};
            idx_d   = idx_q + 5'd1;
            if (idx_q == nsamp_q - 5'd1) state_d = S_IDLE;
            if (L1A) miss_inc = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output stage: refill when empty or popped, using only entries written two edges ago.
   always_comb begin
      pop      = dout_vld_q && DOUT_READY;
      load     = !dout_vld_q || pop;
      head_nxt = rd_ptr_q + (ADDR_W+1)'(pop);
      avail    = (wr_ptr_dly_q != head_nxt);
      mem_rd   = mem[head_nxt[ADDR_W-1:0]];
   end

   // Control state, counters and buffer pointers.
   always_ff @(posedge RDCLK) begin
      if (RST) begin
         state_q      <= S_IDLE;
         nsamp_q      <= 5'd0;
         idx_q        <= 5'd0;
         evt_q        <= 12'd0;
         l1a_cnt_q    <= 12'd0;
         miss_cnt_q   <= 8'd0;
         cnt_q        <= '0;
         wr_ptr_q     <= '0;
         wr_ptr_dly_q <= '0;
         rd_ptr_q     <= '0;
      end else begin
         state_q      <= state_d;
         nsamp_q      <= nsamp_d;
         idx_q        <= idx_d;
         evt_q        <= evt_d;
         l1a_cnt_q    <= l1a_cnt_q + 12'(L1A);
         if (miss_inc && miss_cnt_q != 8'hFF) miss_cnt_q <= miss_cnt_q + 8'd1;
         wr_ptr_q     <= wr_ptr_q + (ADDR_W+1)'(wr_en);
         wr_ptr_dly_q <= wr_ptr_q;
         rd_ptr_q     <= head_nxt;
         case ({wr_en, pop})
            2'b10:   cnt_q <= cnt_q + (ADDR_W+1)'(1);
            2'b01:   cnt_q <= cnt_q - (ADDR_W+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Sample buffer storage; contents are invalidated by the pointer reset alone.
   always_ff @(posedge RDCLK) begin
      if (wr_en) mem[wr_ptr_q[ADDR_W-1:0]] <= wr_word;
   end

   // Registered output word; holds while stalled.
   always_ff @(posedge RDCLK) begin
      if (RST) begin
         dout_data_q  <= '0;
         dout_evt_q   <= 12'd0;
         dout_first_q <= 1'b0;
         dout_last_q  <= 1'b0;
         dout_err_q   <= 1'b0;
         dout_vld_q   <= 1'b0;
      end else if (load) begin
         dout_vld_q <= avail;
         if (avail) begin
            {dout_err_q, dout_last_q, dout_first_q, dout_evt_q, dout_data_q} <= mem_rd;
         end
      end
   end

   assign DOUT       = dout_data_q;
   assign DOUT_EVT   = dout_evt_q;
   assign DOUT_FIRST = dout_first_q;
   assign DOUT_LAST  = dout_last_q;
   assign DOUT_ERR   = dout_err_q;
   assign DOUT_VALID = dout_vld_q;
   assign BUSY       = (state_q == S_CAPTURE);
   assign L1A_CNT    = l1a_cnt_q;
   assign MISS_CNT   = miss_cnt_q;
   assign BUF_CNT    = cnt_q;

endmodule

// File: tb/tb_pipe_sample_reader.sv
// Bench for pipe_sample_reader: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based event model.
module tb_pipe_sample_reader;

   localparam int DW = 192;

   logic            RDCLK, RST, PIP_VALID, L1A, DOUT_READY;
   logic [4:0]      NSAMP;
   logic [DW-1:0]   PIPOUT, DOUT;
   logic [11:0]     DOUT_EVT, L1A_CNT;
   logic            DOUT_FIRST, DOUT_LAST, DOUT_ERR, DOUT_VALID, BUSY;
   logic [7:0]      MISS_CNT;
   logic [5:0]      BUF_CNT;

   pipe_sample_reader #(.DW(DW), .ADDR_W(5)) dut (
      .RDCLK(RDCLK), .RST(RST), .PIP_VALID(PIP_VALID), .L1A(L1A), .NSAMP(NSAMP),
      .PIPOUT(PIPOUT), .DOUT(DOUT), .DOUT_EVT(DOUT_EVT), .DOUT_FIRST(DOUT_FIRST),
      .DOUT_LAST(DOUT_LAST), .DOUT_ERR(DOUT_ERR), .DOUT_VALID(DOUT_VALID),
      .DOUT_READY(DOUT_READY), .BUSY(BUSY), .L1A_CNT(L1A_CNT), .MISS_CNT(MISS_CNT),
      .BUF_CNT(BUF_CNT)
   );

   initial begin
      RDCLK = 1'b0;
      forever #5 RDCLK = ~RDCLK;
   end

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit rand_data = 1'b0;
   bit chk_en    = 1'b0;

   // Model: every buffered word carries the edge index at which it was written.
   typedef struct {
      logic [DW-1:0] data;
      logic [11:0]   evt;
      logic          first;
      logic          last;
      logic          err;
      int            wedge;
   } word_t;

   word_t mq[$];
   int    m_edge = 0;
   int    m_l1a  = 0;
   int    m_miss = 0;
   int    m_rem  = 0;
   int    m_idx  = 0;
   int    m_n    = 0;
   int    m_evt  = 0;
   bit    m_vld  = 1'b0;
   int    pop_cnt  = 0;
   int    err_pops = 0;
   bit    lp_first = 1'b0;
   bit    lp_last  = 1'b0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge RDCLK) begin
      word_t w;
      int    occ;
      int    n;
      bit    pop_now;
      if (RST) begin
         mq.delete();
         m_l1a = 0; m_miss = 0; m_rem = 0; m_vld = 1'b0;
      end else begin
         occ     = mq.size();
         pop_now = m_vld && DOUT_READY;
         if (pop_now) begin
            pop_cnt++;
            if (mq[0].err) err_pops++;
            lp_first = mq[0].first;
            lp_last  = mq[0].last;
            void'(mq.pop_front());
         end
         if (m_rem > 0) begin
            w.data = PIPOUT; w.evt = 12'(m_evt); w.first = 1'b0;
            w.last = (m_idx == m_n - 1); w.err = !PIP_VALID; w.wedge = m_edge;
            mq.push_back(w);
            m_idx++; m_rem--;
            if (L1A && m_miss < 255) m_miss++;
         end else if (L1A) begin
            n = (NSAMP == 0 || NSAMP > 16) ? 16 : int'(NSAMP);
            if (PIP_VALID && (32 - occ) >= n) begin
               w.data = PIPOUT; w.evt = 12'(m_l1a); w.first = 1'b1;
               w.last = (n == 1); w.err = 1'b0; w.wedge = m_edge;
               mq.push_back(w);
               m_n = n; m_evt = m_l1a; m_idx = 1; m_rem = n - 1;
            end else if (m_miss < 255) begin
               m_miss++;
            end
         end
         if (L1A) m_l1a = (m_l1a + 1) % 4096;
         m_vld = 1'b0;
         if (mq.size() > 0) m_vld = (mq[0].wedge <= m_edge - 2);
      end
      m_edge++;
   end

   always @(negedge RDCLK) begin
      if (chk_en) begin
         chk("BUSY", DW'(BUSY), DW'(m_rem > 0));
         chk("L1A_CNT", DW'(L1A_CNT), DW'(m_l1a));
         chk("MISS_CNT", DW'(MISS_CNT), DW'(m_miss));
         chk("BUF_CNT", DW'(BUF_CNT), DW'(mq.size()));
         chk("DOUT_VALID", DW'(DOUT_VALID), DW'(m_vld));
         if (m_vld && mq.size() > 0) begin
            chk("DOUT", DOUT, mq[0].data);
            chk("DOUT_EVT", DW'(DOUT_EVT), DW'(mq[0].evt));
            chk("DOUT_FIRST", DW'(DOUT_FIRST), DW'(mq[0].first));
            chk("DOUT_LAST", DW'(DOUT_LAST), DW'(mq[0].last));
            chk("DOUT_ERR", DW'(DOUT_ERR), DW'(mq[0].err));
         end
      end
   end

   task automatic step();
      @(negedge RDCLK);
      cyc++;
      PIPOUT = rand_data ? DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()})
                         : DW'(cyc);
   endtask

   task automatic do_reset();
      RST = 1'b1; L1A = 1'b0;
      step(); step();
      RST = 1'b0;
      step();
   endtask

   task automatic trig();
      L1A = 1'b1;
      step();
      L1A = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] pip0;
      RST = 1'b1; L1A = 1'b0; PIP_VALID = 1'b1; DOUT_READY = 1'b1;
      NSAMP = 5'd8; PIPOUT = '0;
      step(); step();
      chk_en = 1'b1;
      RST = 1'b0;
      step();

      // Reset state
      chk("rst_DOUT", DOUT, '0);
      chk("rst_VALID", DW'(DOUT_VALID), '0);
      chk("rst_L1A_CNT", DW'(L1A_CNT), '0);

      // 1: single 8-sample event, data = cycle index
      rand_data = 1'b0; NSAMP = 5'd8; DOUT_READY = 1'b1;
      pip0 = PIPOUT;
      trig();
      chk("t1_vld_k0", DW'(DOUT_VALID), '0);
      step();
      chk("t1_vld_k1", DW'(DOUT_VALID), '0);
      step();
      chk("t1_vld_k2", DW'(DOUT_VALID), DW'(1));
      chk("t1_word0", DOUT, pip0);
      chk("t1_first", DW'(DOUT_FIRST), DW'(1));
      chk("t1_evt", DW'(DOUT_EVT), '0);
      for (int i = 1; i < 8; i++) begin
         step();
         chk("t1_word", DOUT, pip0 + DW'(i));
      end
      chk("t1_last", DW'(DOUT_LAST), DW'(1));
      step();
      chk("t1_drained", DW'(DOUT_VALID), '0);

      // 2: fill the buffer with four events, fifth trigger refused, then drain
      do_reset();
      rand_data = 1'b1; DOUT_READY = 1'b0; NSAMP = 5'd8;
      for (int e = 0; e < 4; e++) begin
         trig();
         repeat (7) step();
      end
      chk("t2_full", DW'(BUF_CNT), DW'(32));
      trig();
      chk("t2_miss", DW'(MISS_CNT), DW'(1));
      chk("t2_l1a", DW'(L1A_CNT), DW'(5));
      pop_cnt = 0;
      DOUT_READY = 1'b1;
      repeat (36) step();
      chk("t2_pops", DW'(pop_cnt), DW'(32));
      chk("t2_empty", DW'(BUF_CNT), '0);

      // 3: triggers during capture cycles 1 and 7 refused, cycle 8 accepted
      do_reset();
      trig();
      trig();
      repeat (5) step();
      trig();
      chk("t3_miss", DW'(MISS_CNT), DW'(2));
      chk("t3_l1a", DW'(L1A_CNT), DW'(3));
      chk("t3_idle", DW'(BUSY), '0);
      trig();
      chk("t3_busy", DW'(BUSY), DW'(1));
      chk("t3_miss2", DW'(MISS_CNT), DW'(2));
      repeat (12) step();

      // 4: NSAMP=0 coerced to 16, NSAMP=1 single word
      do_reset();
      NSAMP = 5'd0; pop_cnt = 0;
      trig();
      repeat (20) step();
      chk("t4_n0_words", DW'(pop_cnt), DW'(16));
      NSAMP = 5'd1; pop_cnt = 0;
      trig();
      chk("t4_n1_busy", DW'(BUSY), '0);
      repeat (4) step();
      chk("t4_n1_words", DW'(pop_cnt), DW'(1));
      chk("t4_n1_flags", DW'({lp_first, lp_last}), DW'(3));

      // 5: PIP_VALID gap mid-capture, then a trigger while PIP_VALID is low
      NSAMP = 5'd8; pop_cnt = 0; err_pops = 0;
      trig();
      step();
      PIP_VALID = 1'b0;
      step(); step();
      PIP_VALID = 1'b1;
      repeat (10) step();
      chk("t5_err_words", DW'(err_pops), DW'(2));
      chk("t5_len", DW'(pop_cnt), DW'(8));
      PIP_VALID = 1'b0;
      trig();
      PIP_VALID = 1'b1;
      chk("t5_miss", DW'(MISS_CNT), DW'(1));

      // 6: reset in capture cycle 3 with 10 words buffered
      do_reset();
      DOUT_READY = 1'b0; NSAMP = 5'd7;
      trig();
      repeat (6) step();
      NSAMP = 5'd16;
      trig();
      step(); step();
      chk("t6_pre_cnt", DW'(BUF_CNT), DW'(10));
      RST = 1'b1;
      step();
      RST = 1'b0;
      chk("t6_cnt", DW'(BUF_CNT), '0);
      chk("t6_vld", DW'(DOUT_VALID), '0);
      chk("t6_busy", DW'(BUSY), '0);
      chk("t6_l1a", DW'(L1A_CNT), '0);
      chk("t6_miss", DW'(MISS_CNT), '0);
      chk("t6_dout", DOUT, '0);
      DOUT_READY = 1'b1; NSAMP = 5'd4;
      trig();
      step(); step();
      chk("t6_new_vld", DW'(DOUT_VALID), DW'(1));
      chk("t6_new_evt", DW'(DOUT_EVT), '0);
      repeat (6) step();

      // 7: random backpressure and triggers, then saturate MISS_CNT and wrap L1A_CNT
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         DOUT_READY = ($urandom_range(0, 1) == 1);
         L1A        = ($urandom_range(0, 2) == 0);
         NSAMP      = 5'($urandom_range(0, 31));
         PIP_VALID  = ($urandom_range(0, 9) != 0);
         step();
      end
      DOUT_READY = 1'b0; PIP_VALID = 1'b1; L1A = 1'b1;
      repeat (3500) step();
      L1A = 1'b0;
      chk("t7_miss_sat", DW'(MISS_CNT), DW'(255));
      DOUT_READY = 1'b1;
      repeat (40) step();
      chk("t7_drained", DW'(BUF_CNT), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
